// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stall_ctrl
//  Purpose  : Freeze/flush sequencer for the 5-stage pipeline: multi-cycle
//             SRAM stalls, load-use bubbles, branch flushes, stall counter.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_stall_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             sram_ready,
    output logic             freeze_pc,
    output logic             freeze_if_id,
    output logic             freeze_id_exe,
    output logic             freeze_exe_mem,
    output logic             freeze_mem_wb,
    output logic             flush_if_id,
    output logic             flush_id_exe,
    output logic             sram_start,
    output logic             busy,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_DONE     = 2'd2,
        S_ERROR    = 2'd3
    } state_t;

    localparam int               c_WAIT_W    = 16;
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX   = {CNT_W{1'b1}};

    state_t              r_state;
    state_t              w_next_state;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [c_WAIT_W-1:0] w_wait_cnt_next;
    logic [CNT_W-1:0]    r_stall_cnt;

    logic w_freeze_all;
    logic w_hold_front;
    logic w_flush_if_id;
    logic w_flush_id_exe;
    logic w_start;
    logic w_busy;
    logic w_err;

    // Normal issue decision; branch wins over a load-use hazard.
    logic w_issue_hold;
    logic w_issue_flush_if_id;
    logic w_issue_flush_id_exe;

    always_comb begin
        w_issue_hold         = 1'b0;
        w_issue_flush_if_id  = 1'b0;
        w_issue_flush_id_exe = 1'b0;
        if (branch_taken) begin
            w_issue_flush_if_id  = 1'b1;
            w_issue_flush_id_exe = 1'b1;
        end else if (hazard) begin
            w_issue_hold         = 1'b1;
            w_issue_flush_id_exe = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_wait_cnt_next;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        w_freeze_all    = 1'b0;
        w_hold_front    = 1'b0;
        w_flush_if_id   = 1'b0;
        w_flush_id_exe  = 1'b0;
        w_start         = 1'b0;
        w_busy          = 1'b0;
        w_err           = 1'b0;

        case (r_state)
            S_RUN: begin
                if (mem_req) begin
                    // Memory stall outranks branch/hazard; those are
                    // re-evaluated in the DONE release cycle.
                    w_start         = 1'b1;
                    w_freeze_all    = 1'b1;
                    w_wait_cnt_next = '0;
                    w_next_state    = S_MEM_WAIT;
                end else begin
                    w_hold_front   = w_issue_hold;
                    w_flush_if_id  = w_issue_flush_if_id;
                    w_flush_id_exe = w_issue_flush_id_exe;
                end
            end
            S_MEM_WAIT: begin
                w_freeze_all = 1'b1;
                w_busy       = 1'b1;
                if (sram_ready) begin
                    w_next_state = S_DONE;
                end else if (r_wait_cnt == c_WAIT_LAST) begin
                    w_next_state = S_ERROR;
                end else begin
                    w_wait_cnt_next = r_wait_cnt + c_WAIT_W'(1);
                end
            end
            S_DONE: begin
                // mem_req still refers to the completed access; ignore it.
                w_hold_front   = w_issue_hold;
                w_flush_if_id  = w_issue_flush_if_id;
                w_flush_id_exe = w_issue_flush_id_exe;
                w_next_state   = S_RUN;
            end
            S_ERROR: begin
                w_freeze_all = 1'b1;
                w_err        = 1'b1;
            end
            default: begin
                w_next_state = S_RUN;
            end
        endcase
    end

    // Outputs are forced low for the whole time reset is asserted.
    assign freeze_pc      = rst & (w_freeze_all | w_hold_front);
    assign freeze_if_id   = rst & (w_freeze_all | w_hold_front);
    assign freeze_id_exe  = rst & w_freeze_all;
    assign freeze_exe_mem = rst & w_freeze_all;
    assign freeze_mem_wb  = rst & w_freeze_all;
    assign flush_if_id    = rst & w_flush_if_id;
    assign flush_id_exe   = rst & w_flush_id_exe;
    assign sram_start     = rst & w_start;
    assign busy           = rst & w_busy;
    assign timeout_err    = rst & w_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (freeze_pc && (r_stall_cnt != c_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Central freeze/flush sequencer for the 5-stage pipeline.
- Drives the freeze and flush inputs of every inter-stage register: IF/ID, ID/EXE, EXE/MEM, MEM/WB, plus the PC.
- Sequences multi-cycle SRAM accesses from the MEM stage.
- Turns load-use hazards into bubbles and taken branches into flushes.
- Keeps a saturating stall-cycle counter and raises a sticky timeout error when the SRAM never answers.

Parameters:
- TIMEOUT, 64: max MEM_WAIT cycles before error; legal range 2..2^16-1.
- CNT_W, 16: width of stall_cnt.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- hazard  in  1  load-use hazard from hazard unit (ID stage).
- branch_taken  in  1  taken branch resolved in EXE.
- mem_req  in  1  MEM-stage instruction is a load/store.
- sram_ready  in  1  SRAM access complete; sampled only in MEM_WAIT.
- freeze_pc  out  1  hold PC.
- freeze_if_id  out  1  hold IF/ID register.
- freeze_id_exe  out  1  hold ID/EXE register.
- freeze_exe_mem  out  1  hold EXE/MEM register.
- freeze_mem_wb  out  1  hold MEM/WB register.
- flush_if_id  out  1  clear IF/ID register.
- flush_id_exe  out  1  clear ID/EXE register (bubble).
- sram_start  out  1  one-cycle access start pulse to SRAM controller.
- busy  out  1  state is MEM_WAIT.
- timeout_err  out  1  sticky error flag.
- stall_cnt  out  CNT_W  cycles with freeze_pc=1, saturating.

Behaviour:
- Reset (rst=0, async): state=RUN, wait counter=0, timeout_err=0, stall_cnt=0. All outputs 0 while in reset.
- State register is sequential. All control outputs are combinational from state and inputs, so they act in the same cycle.
- States and transitions:
  - RUN, mem_req=1: sram_start=1, all five freezes=1, flushes=0. next=MEM_WAIT, wait counter cleared.
  - RUN, mem_req=0: normal issue (rules below). Stay in RUN.
  - MEM_WAIT: all five freezes=1, flushes=0, busy=1, sram_start=0.
    - sram_ready=1: next=DONE.
    - Else if wait counter==TIMEOUT-1: next=ERROR.
    - Else counter+1.
  - DONE: single release cycle. Freezes from memory = 0, mem_req ignored (same instruction still in MEM), normal issue rules apply. next=RUN unconditionally.
  - ERROR: all five freezes=1, timeout_err=1. Remains until reset; no other exit.
- Normal issue rules (RUN with mem_req=0, and DONE), priority branch > hazard:
  - branch_taken=1: flush_if_id=1, flush_id_exe=1, no freezes; hazard ignored.
  - hazard=1 (no branch): freeze_pc=1, freeze_if_id=1, flush_id_exe=1; downstream freezes 0.
  - Neither: all outputs 0.
- Memory stall beats branch and hazard. In a RUN cycle with mem_req=1, branch/hazard are not acted on; they are re-evaluated in DONE.
- The first sram_ready is sampled in the cycle after sram_start, so minimum access = 1 MEM_WAIT cycle. Stall seen by PC = 2 cycles (start cycle + 1 wait).
- sram_ready outside MEM_WAIT is ignored.
- stall_cnt increments on every clock edge where freeze_pc=1, including ERROR. Saturates at 2^CNT_W-1; no wrap.
- Reset mid-MEM_WAIT aborts to RUN immediately. sram_start is not reissued until mem_req is seen again in RUN.

Test Plan:
1. Reset, then idle 5 cycles with all inputs 0 -> all outputs 0, stall_cnt=0.
2. mem_req=1 at cycle 0, sram_ready=1 at cycle 3 -> sram_start high only at cycle 0; all freezes high cycles 0..3, busy cycles 1..3; cycle 4 DONE with freezes 0 even though mem_req=1; cycle 5 RUN re-triggers only if a new mem_req; stall_cnt=4.
3. hazard=1 for 2 cycles, no mem_req -> freeze_pc, freeze_if_id, flush_id_exe high both cycles, others 0; stall_cnt=2. Then hazard=1 with branch_taken=1 same cycle -> only flush_if_id and flush_id_exe high.
4. mem_req=1 with branch_taken=1 in RUN -> memory stall taken, flushes 0. In the DONE cycle with branch_taken still 1 -> flush_if_id=1 and flush_id_exe=1.
5. TIMEOUT=8, mem_req=1, sram_ready never asserted -> after 8 MEM_WAIT cycles state=ERROR, timeout_err=1 and all freezes remain 1; a later sram_ready=1 has no effect; rst=0 clears everything.
6. CNT_W=4, hazard held 20 cycles -> stall_cnt reaches 15 and holds. Assert rst=0 mid-MEM_WAIT -> outputs drop to 0 asynchronously and state=RUN after release.
